// File: rtl/regfile_wb_initiator.sv
// regfile_wb_initiator
// Wishbone classic single-transfer master for the ECC register file.
// A command is accepted on the valid/ready interface and becomes exactly one
// Wishbone cycle. The master waits for the slave ack, or gives up after
// TIMEOUT cycles, and then returns the result on the response interface.
// It also keeps a wrapping count of acked transfers and a saturating count
// of timeouts.
module regfile_wb_initiator #(
  parameter int WORD_SIZE    = 32,
  parameter int WHISBONE_ADR = 32,
  parameter int TIMEOUT      = 255,
  parameter int TIMEOUTSIZE  = 8,
  parameter int COUNTERSIZE  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // command interface
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [WHISBONE_ADR-1:0] cmd_adr_i,
  input  logic [WORD_SIZE-1:0]    cmd_dat_i,
  input  logic [3:0]              cmd_sel_i,
  // Wishbone master port
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [3:0]              wbm_sel_o,
  output logic [WHISBONE_ADR-1:0] wbm_adr_o,
  output logic [WORD_SIZE-1:0]    wbm_dat_o,
  input  logic [WORD_SIZE-1:0]    wbm_dat_i,
  input  logic                    wbm_ack_i,
  // response interface
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [WORD_SIZE-1:0]    rsp_dat_o,
  output logic                    rsp_err_o,
  // status counters
  output logic [COUNTERSIZE-1:0]  txn_count_o,
  output logic [COUNTERSIZE-1:0]  err_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A TIMEOUT of zero means wait for the ack forever.
  localparam logic                   TMO_EN   = (TIMEOUT != 0);
  localparam logic [TIMEOUTSIZE-1:0] TMO_LAST = TIMEOUTSIZE'(TIMEOUT - 1);

  // Transaction counter: plain modulo-2^COUNTERSIZE increment.
  function automatic logic [COUNTERSIZE-1:0] wrap_inc(input logic [COUNTERSIZE-1:0] v);
    return v + COUNTERSIZE'(1);
  endfunction

  // Error counter: sticks at all-ones instead of wrapping back to zero.
  function automatic logic [COUNTERSIZE-1:0] sat_inc(input logic [COUNTERSIZE-1:0] v);
    return (&v) ? v : v + COUNTERSIZE'(1);
  endfunction

  state_t                  state_q, state_d;
  logic                    cyc_q, cyc_d;
  logic                    we_q, we_d;
  logic [3:0]              sel_q, sel_d;
  logic [WHISBONE_ADR-1:0] adr_q, adr_d;
  logic [WORD_SIZE-1:0]    dat_q, dat_d;
  logic [TIMEOUTSIZE-1:0]  tmo_q, tmo_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0]    rsp_dat_q, rsp_dat_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [COUNTERSIZE-1:0]  txn_q, txn_d;
  logic [COUNTERSIZE-1:0]  err_q, err_d;
  logic                    tmo_hit;

  // The last allowed wait cycle has been reached (ack still takes priority).
  assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

  // State register; reset drops any transfer in flight without a response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept in IDLE, finish on ack or timeout, release on rsp_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cmd_valid_i) state_d = ST_BUS;
      ST_BUS:  if (wbm_ack_i || tmo_hit) state_d = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and counters; every value holds unless an event below updates it.
  always_comb begin
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    tmo_d       = tmo_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    txn_d       = txn_q;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          // Capture the command once; later changes on cmd_* are ignored.
          cyc_d = 1'b1;
          we_d  = cmd_we_i;
          adr_d = cmd_adr_i;
          dat_d = cmd_dat_i;
          sel_d = cmd_we_i ? cmd_sel_i : 4'hF;
          tmo_d = '0;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          txn_d       = wrap_inc(txn_q);
        end else if (tmo_hit) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          err_d       = sat_inc(err_q);
        end else begin
          tmo_d = tmo_q + TIMEOUTSIZE'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) rsp_valid_d = 1'b0;
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      txn_q       <= '0;
      err_q       <= '0;
    end else begin
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      txn_q       <= txn_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign txn_count_o = txn_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_regfile_wb_initiator.sv
// Testbench for regfile_wb_initiator: directed transfers against a
// transaction-level reference model, compared on every falling clock edge.
module tb_regfile_wb_initiator;
  localparam int TMO = 8;
  localparam int CS  = 2;
  localparam int CMAX = (1 << CS) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;
  logic [CS-1:0] txn_count, err_count;

  always #5 clk = ~clk;

  regfile_wb_initiator #(
    .WORD_SIZE(32), .WHISBONE_ADR(32), .TIMEOUT(TMO), .TIMEOUTSIZE(8), .COUNTERSIZE(CS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_we_o(wbm_we), .wbm_sel_o(wbm_sel),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .txn_count_o(txn_count), .err_count_o(err_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave: acks after slv_wait wait states (negative = never); spur injects a stray ack.
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic        spur = 1'b0;
  int          bus_cnt = 0;
  always @(negedge clk) begin
    if (wbm_cyc && wbm_stb) begin
      wbm_ack   <= ((slv_wait >= 0) && (bus_cnt == slv_wait)) || spur;
      wbm_dat_i <= slv_rdata;
      bus_cnt   <= bus_cnt + 1;
    end else begin
      wbm_ack   <= spur;
      wbm_dat_i <= 32'hFFFF_0000;
      bus_cnt   <= 0;
    end
  end

  // Reference model: one outstanding transfer, either on the bus or awaiting pickup.
  logic        m_busy = 1'b0, m_we = 1'b0, m_rv = 1'b0, m_err = 1'b0;
  logic [31:0] m_adr = '0, m_dat = '0, m_rdat = '0;
  logic [3:0]  m_sel = '0;
  int          m_age = 0, m_txn = 0, m_errc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_we <= 1'b0; m_rv <= 1'b0; m_err <= 1'b0;
      m_adr <= '0; m_dat <= '0; m_rdat <= '0; m_sel <= '0;
      m_age <= 0; m_txn <= 0; m_errc <= 0;
    end else if (!m_busy && !m_rv) begin
      if (cmd_valid) begin
        m_busy <= 1'b1; m_we <= cmd_we; m_adr <= cmd_adr; m_dat <= cmd_dat;
        m_sel <= cmd_we ? cmd_sel : 4'hF; m_age <= 0;
      end
    end else if (m_busy) begin
      if (wbm_ack) begin
        m_busy <= 1'b0; m_rv <= 1'b1; m_err <= 1'b0;
        m_rdat <= m_we ? 32'h0 : wbm_dat_i;
        m_txn <= (m_txn + 1) % (CMAX + 1);
      end else if (TMO != 0 && m_age + 1 == TMO) begin
        m_busy <= 1'b0; m_rv <= 1'b1; m_err <= 1'b1; m_rdat <= 32'h0;
        m_errc <= (m_errc == CMAX) ? m_errc : m_errc + 1;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (rsp_ready) begin
      m_rv <= 1'b0;
    end
  end

  // Compare every output with the model each cycle.
  always @(negedge clk) begin
    chk("cmd_ready", 64'(cmd_ready), 64'(!m_busy && !m_rv));
    chk("wbm_cyc", 64'(wbm_cyc), 64'(m_busy));
    chk("wbm_stb", 64'(wbm_stb), 64'(m_busy));
    chk("wbm_we", 64'(wbm_we), 64'(m_we));
    chk("wbm_sel", 64'(wbm_sel), 64'(m_sel));
    chk("wbm_adr", 64'(wbm_adr), 64'(m_adr));
    chk("wbm_dat", 64'(wbm_dat_o), 64'(m_dat));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    chk("rsp_dat", 64'(rsp_dat), 64'(m_rdat));
    chk("rsp_err", 64'(rsp_err), 64'(m_err));
    chk("txn_count", 64'(txn_count), 64'(m_txn));
    chk("err_count", 64'(err_count), 64'(m_errc));
  end

  // Present a command and return at the falling edge right after acceptance.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    int g;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    g = 0;
    while (!cmd_ready && g < 50) begin @(negedge clk); g++; end
    if (!cmd_ready) chk("accept_bound", 64'd0, 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
  endtask

  // Wait for the response, counting cyc-high cycles and capturing the first bus beat.
  task automatic wait_rsp(output int n, output logic [31:0] adr_s, output logic [31:0] dat_s,
                          output logic [3:0] sel_s);
    int g;
    n = 0; g = 0; adr_s = '0; dat_s = '0; sel_s = '0;
    while (!rsp_valid && g < 100) begin
      if (wbm_cyc) begin
        if (n == 0) begin adr_s = wbm_adr; dat_s = wbm_dat_o; sel_s = wbm_sel; end
        n++;
      end
      @(negedge clk); g++;
    end
    if (!rsp_valid) chk("rsp_bound", 64'd0, 64'd1);
  endtask

  // Stall the response for 'stall' cycles, then consume it.
  task automatic handshake(input int stall, input logic [31:0] hold_dat);
    repeat (stall) begin
      chk("bp_cmd_ready_low", 64'(cmd_ready), 64'd0);
      chk("bp_rsp_dat_hold", 64'(rsp_dat), 64'(hold_dat));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int          n;
  logic [31:0] a_s, d_s;
  logic [3:0]  s_s;

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_cyc", 64'(wbm_cyc), 64'd0);
    chk("reset_txn", 64'(txn_count), 64'd0);

    // Write, zero wait states; read data on the bus must not leak into rsp_dat.
    slv_wait = 0; slv_rdata = 32'h55AA_55AA;
    issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(n, a_s, d_s, s_s);
    chk("wr_stb_cycles", 64'(n), 64'd1);
    chk("wr_bus_adr", 64'(a_s), 64'h3000_0004);
    chk("wr_bus_dat", 64'(d_s), 64'hDEAD_BEEF);
    chk("wr_rsp_dat", 64'(rsp_dat), 64'd0);
    chk("wr_rsp_err", 64'(rsp_err), 64'd0);
    chk("wr_txn", 64'(txn_count), 64'd1);
    handshake(0, 32'h0);

    // Read, 3 wait states, write-style sel on the command must become 4'hF.
    slv_wait = 3; slv_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 32'h3000_0004, 32'h0, 4'h3);
    wait_rsp(n, a_s, d_s, s_s);
    chk("rd_stb_cycles", 64'(n), 64'd4);
    chk("rd_sel", 64'(s_s), 64'hF);
    chk("rd_rsp_dat", 64'(rsp_dat), 64'hDEAD_BEEF);
    chk("rd_txn", 64'(txn_count), 64'd2);
    handshake(0, 32'h0);

    // Timeout, then a stray ack while idle.
    slv_wait = -1;
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    wait_rsp(n, a_s, d_s, s_s);
    chk("tmo_stb_cycles", 64'(n), 64'd8);
    chk("tmo_rsp_err", 64'(rsp_err), 64'd1);
    chk("tmo_rsp_dat", 64'(rsp_dat), 64'd0);
    chk("tmo_err_count", 64'(err_count), 64'd1);
    chk("tmo_txn", 64'(txn_count), 64'd2);
    handshake(0, 32'h0);
    repeat (2) @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_err_count", 64'(err_count), 64'd1);
    chk("spur_txn", 64'(txn_count), 64'd2);
    chk("spur_rsp_valid", 64'(rsp_valid), 64'd0);

    // Backpressure: second command waits until the first response is taken.
    slv_wait = 1; slv_rdata = 32'h1234_5678;
    issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0014;
    cmd_dat = 32'hCAFE_F00D; cmd_sel = 4'h5;
    wait_rsp(n, a_s, d_s, s_s);
    handshake(5, 32'h1234_5678);
    chk("bp_ready_after", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    chk("bp_second_cyc", 64'(wbm_cyc), 64'd1);
    chk("bp_second_adr", 64'(wbm_adr), 64'h3000_0014);
    chk("bp_second_sel", 64'(wbm_sel), 64'h5);
    cmd_valid = 1'b0;
    wait_rsp(n, a_s, d_s, s_s);
    handshake(0, 32'h0);

    // Reset in the middle of a bus cycle.
    slv_wait = -1;
    issue(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cyc", 64'(wbm_cyc), 64'd0);
    chk("rst_stb", 64'(wbm_stb), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_txn", 64'(txn_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    slv_wait = 2; slv_rdata = 32'hA5A5_5A5A;
    issue(1'b0, 32'h3000_0024, 32'h0, 4'hF);
    wait_rsp(n, a_s, d_s, s_s);
    chk("post_rst_stb_cycles", 64'(n), 64'd3);
    chk("post_rst_rsp_dat", 64'(rsp_dat), 64'hA5A5_5A5A);
    chk("post_rst_txn", 64'(txn_count), 64'd1);
    handshake(0, 32'h0);

    // Counter wrap and saturation from a clean reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      slv_wait = (i < 5) ? 0 : -1;
      issue(1'b1, 32'h3000_0100 + 32'(i), 32'(i), 4'hF);
      wait_rsp(n, a_s, d_s, s_s);
      handshake(0, 32'h0);
    end
    chk("wrap_txn", 64'(txn_count), 64'd1);
    chk("sat_err_count", 64'(err_count), 64'd3);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
